// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// Start-of-transmission sequencer for the JESD204 TPL DAC datapath (link_clk domain).
// Optional ARMED timeout is compiled in with `define TPL_DAC_SYNC_TIMEOUT_EN.
module ad_ip_jesd204_tpl_dac_sync_ctrl #(
    parameter int EXT_SYNC      = 0,
    parameter int DELAY_WIDTH   = 8,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     link_clk,
    input  logic                     reset,
    input  logic                     link_ready,
    input  logic                     dac_sync,
    input  logic                     dac_ext_sync_arm,
    input  logic                     dac_ext_sync_disarm,
    input  logic                     dac_sync_in,
    input  logic [DELAY_WIDTH-1:0]   cfg_start_delay,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    output logic                     dac_sync_out,
    output logic                     dac_data_enable,
    output logic                     dac_sync_in_status,
    output logic [7:0]               dac_sync_count,
    output logic                     dac_sync_timeout
);

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_ARMED = 2'd1;
    localparam logic [1:0] STATE_DELAY = 2'd2;
    localparam logic [1:0] STATE_RUN   = 2'd3;

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [DELAY_WIDTH-1:0] cnt;
    logic                   sync_in_d;
    logic                   ext_edge;
    logic                   arm_ok;
    logic                   timeout_hit;
    logic                   timeout_fire;
    logic                   entering_delay;
    logic                   entering_armed;
    logic                   entering_run;

    assign ext_edge = dac_sync_in & ~sync_in_d;
    assign arm_ok   = dac_ext_sync_arm && (EXT_SYNC != 0);

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        state_next   = state;
        timeout_fire = 1'b0;
        case (state)
            STATE_IDLE: begin
                if (dac_sync)
                    state_next = STATE_DELAY;
                else if (arm_ok)
                    state_next = STATE_ARMED;
            end
            STATE_ARMED: begin
                if (dac_ext_sync_disarm)
                    state_next = STATE_IDLE;
                else if (dac_sync || ext_edge)
                    state_next = STATE_DELAY;
                else if (timeout_hit) begin
                    state_next   = STATE_IDLE;
                    timeout_fire = 1'b1;
                end
            end
            STATE_DELAY: begin
                if (cnt == '0 && link_ready)
                    state_next = STATE_RUN;
            end
            STATE_RUN: begin
                // Losing the link outranks any request arriving in the same cycle.
                if (!link_ready)
                    state_next = STATE_IDLE;
                else if (dac_sync)
                    state_next = STATE_DELAY;
                else if (arm_ok)
                    state_next = STATE_ARMED;
            end
            default: state_next = STATE_IDLE;
        endcase
    end

    // A resync from RUN counts as a fresh DELAY entry and reloads the counter.
    assign entering_delay = (state_next == STATE_DELAY) && (state != STATE_DELAY);
    assign entering_armed = (state_next == STATE_ARMED) && (state != STATE_ARMED);
    assign entering_run   = (state == STATE_DELAY) && (state_next == STATE_RUN);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge link_clk or posedge reset) begin
        if (reset) begin
            state              <= STATE_IDLE;
            cnt                <= '0;
            sync_in_d          <= 1'b0;
            dac_sync_out       <= 1'b0;
            dac_data_enable    <= 1'b0;
            dac_sync_in_status <= 1'b0;
            dac_sync_count     <= 8'd0;
        end else begin
            state     <= state_next;
            sync_in_d <= dac_sync_in;

            if (entering_delay)
                cnt <= cfg_start_delay;
            else if (state == STATE_DELAY && link_ready && cnt != '0)
                cnt <= cnt - DELAY_WIDTH'(1);

            dac_sync_out <= entering_run;
            if (entering_run)
                dac_sync_count <= dac_sync_count + 8'd1;

            // Enable follows the current state, so it trails RUN entry and exit by one cycle.
            dac_data_enable    <= (state == STATE_RUN);
            dac_sync_in_status <= (state_next == STATE_ARMED);
        end
    end

`ifdef TPL_DAC_SYNC_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tcnt;
    logic [TIMEOUT_WIDTH-1:0] timeout_cfg;

    assign timeout_hit = (timeout_cfg != '0) && (tcnt == timeout_cfg - TIMEOUT_WIDTH'(1));

    // The timeout value is captured on ARMED entry; later cfg_timeout changes do not affect this wait.
    always_ff @(posedge link_clk or posedge reset) begin
        if (reset) begin
            tcnt             <= '0;
            timeout_cfg      <= '0;
            dac_sync_timeout <= 1'b0;
        end else if (entering_armed) begin
            tcnt             <= '0;
            timeout_cfg      <= cfg_timeout;
            dac_sync_timeout <= 1'b0;
        end else if (state == STATE_ARMED) begin
            tcnt <= tcnt + TIMEOUT_WIDTH'(1);
            if (timeout_fire)
                dac_sync_timeout <= 1'b1;
        end
    end
`else
    logic unused_timeout_inputs;

    assign unused_timeout_inputs = (^cfg_timeout) ^ timeout_fire ^ entering_armed;
    assign timeout_hit           = 1'b0;
    assign dac_sync_timeout      = 1'b0;
`endif

endmodule
